// File: rtl/float_signed_pkg.sv
// Shared field widths, the FloatSigned input word layout and the result class codes
// used by the FloatSigned-to-IEEE return path.
package float_signed_pkg;

  localparam int SIGNED_EXP_W  = 8;
  localparam int SIGNED_FRAC_W = 23;
  localparam int EXP_W         = 5;
  localparam int FRAC_W        = 10;
  localparam int IN_W          = 3 + SIGNED_EXP_W + SIGNED_FRAC_W;

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    ZERO      = 3'd1,
    INF       = 3'd2,
    OVERFLOW  = 3'd3,
    UNDERFLOW = 3'd4
  } cls_e;

  typedef struct packed {
    logic                            is_inf;
    logic                            is_zero;
    logic                            sign;
    logic signed [SIGNED_EXP_W-1:0]  exp;
    logic        [SIGNED_FRAC_W-1:0] frac;
  } fs_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [IN_W-1:0] pack_fs(input fs_t f);
    return f;
  endfunction

  function automatic fs_t unpack_fs(input logic [IN_W-1:0] d);
    return fs_t'(d);
  endfunction

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even of a significand given its guard and sticky bits.
module float_round_rne #(
  parameter int W = 11
) (
  input  logic [W-1:0] sig_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [W-1:0] rounded_o,
  output logic         carry_o,
  output logic         inexact_o
);

  logic inc;

  assign inc                  = guard_i & (sticky_i | sig_i[0]);
  assign {carry_o, rounded_o} = {1'b0, sig_i} + {{W{1'b0}}, inc};
  assign inexact_o            = guard_i | sticky_i;

endmodule

// File: rtl/float_signed_to_float_pipe.sv
// FloatSigned -> packed IEEE float, 3-stage classify/align/round pipe, 1 word/cycle.
// Each stage holds while the one after it is full and stalled; inReady follows outReady combinationally.
module float_signed_to_float_pipe
  import float_signed_pkg::*;
#(
  parameter int SIGNED_EXP  = 8,
  parameter int SIGNED_FRAC = 23,
  parameter int EXP         = 5,
  parameter int FRAC        = 10,
  parameter int DENORMALS   = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic [3+SIGNED_EXP+SIGNED_FRAC-1:0] inData,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [EXP+FRAC:0]                 outData,
  input  logic                              clearCounters,
  output logic [CNT_WIDTH-1:0]              overflowCount,
  output logic [CNT_WIDTH-1:0]              underflowCount,
  output logic [CNT_WIDTH-1:0]              inexactCount
);

  localparam int EW = ((SIGNED_EXP > EXP) ? SIGNED_EXP : EXP) + 2;
  localparam int VW = SIGNED_FRAC + FRAC + 4;
  localparam logic signed [EW-1:0] BIAS = EW'(bias(EXP));
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP) - 1);

  logic adv1, adv2, adv3;
  logic v1_q, v2_q, v3_q;

  assign adv3     = !v3_q || outReady;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  assign inReady  = adv1;
  assign outValid = v3_q;

  // Stage 1: classify on the biased exponent
  logic                   in_inf, in_zero, in_sign;
  logic [SIGNED_EXP-1:0]  in_exp;
  logic [SIGNED_FRAC-1:0] in_frac;
  logic signed [EW-1:0]   e_d;
  cls_e                   cls_d;

  assign {in_inf, in_zero, in_sign, in_exp, in_frac} = inData;
  assign e_d = $signed({{(EW-SIGNED_EXP){in_exp[SIGNED_EXP-1]}}, in_exp}) + BIAS;

  always_comb begin
    cls_d = NORMAL;
    if (in_inf)                          cls_d = INF;
    else if (in_zero)                    cls_d = ZERO;
    else if (e_d >= EMAX)                cls_d = OVERFLOW;
    else if (e_d[EW-1] || e_d == '0)     cls_d = UNDERFLOW;
  end

  cls_e                   cls1_q;
  logic                   sign1_q;
  logic signed [EW-1:0]   e1_q;
  logic [SIGNED_FRAC-1:0] frac1_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      cls1_q  <= NORMAL;
      sign1_q <= 1'b0;
      e1_q    <= '0;
      frac1_q <= '0;
    end else if (adv1) begin
      v1_q <= inValid;
      if (inValid) begin
        cls1_q  <= cls_d;
        sign1_q <= in_sign;
        e1_q    <= e_d;
        frac1_q <= in_frac;
      end
    end
  end

  // Stage 2: align; hidden bit sits at the top of a window wide enough that
  // any non-collapsing denormal shift keeps every bit for the sticky OR.
  logic [VW-1:0]  base, shifted;
  logic [EW-1:0]  sh2;
  logic           collapse;
  logic [FRAC:0]  m2_d;
  logic           g2_d, s2_d;
  logic [EXP-1:0] exp2_d;

  assign base     = {1'b1, frac1_q, {(FRAC+3){1'b0}}};
  assign sh2      = EW'(1) - e1_q;
  assign collapse = sh2 > EW'(FRAC + 2);
  assign shifted  = base >> sh2;

  always_comb begin
    m2_d   = base[VW-1 -: FRAC+1];
    g2_d   = base[VW-FRAC-2];
    s2_d   = |base[VW-FRAC-3:0];
    exp2_d = e1_q[EXP-1:0];
    if (cls1_q == UNDERFLOW) begin
      exp2_d = '0;
      if (DENORMALS == 0 || collapse) begin
        m2_d = '0;
        g2_d = 1'b0;
        s2_d = 1'b1;
      end else begin
        m2_d = shifted[VW-1 -: FRAC+1];
        g2_d = shifted[VW-FRAC-2];
        s2_d = |shifted[VW-FRAC-3:0];
      end
    end
  end

  cls_e           cls2_q;
  logic           sign2_q, g2_q, s2_q;
  logic [FRAC:0]  m2_q;
  logic [EXP-1:0] exp2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_q    <= 1'b0;
      cls2_q  <= NORMAL;
      sign2_q <= 1'b0;
      m2_q    <= '0;
      g2_q    <= 1'b0;
      s2_q    <= 1'b0;
      exp2_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        cls2_q  <= cls1_q;
        sign2_q <= sign1_q;
        m2_q    <= m2_d;
        g2_q    <= g2_d;
        s2_q    <= s2_d;
        exp2_q  <= exp2_d;
      end
    end
  end

  // Stage 3: round, pack, flag
  logic [FRAC:0]     rnd;
  logic              rnd_c, rnd_ix;
  logic [EXP-1:0]    exp_n;
  logic [EXP+FRAC:0] out_d;
  logic              ov_d, uf_d, ix_d;

  float_round_rne #(.W(FRAC + 1)) u_round (
    .sig_i     (m2_q),
    .guard_i   (g2_q),
    .sticky_i  (s2_q),
    .rounded_o (rnd),
    .carry_o   (rnd_c),
    .inexact_o (rnd_ix)
  );

  assign exp_n = exp2_q + EXP'(rnd_c);

  always_comb begin
    out_d = {sign2_q, exp_n, rnd[FRAC-1:0]};
    ov_d  = 1'b0;
    uf_d  = 1'b0;
    ix_d  = rnd_ix;
    case (cls2_q)
      ZERO: begin
        out_d = {sign2_q, {(EXP+FRAC){1'b0}}};
        ix_d  = 1'b0;
      end
      INF: begin
        out_d = {sign2_q, {EXP{1'b1}}, {FRAC{1'b0}}};
        ix_d  = 1'b0;
      end
      OVERFLOW: begin
        out_d = {sign2_q, {EXP{1'b1}}, {FRAC{1'b0}}};
        ov_d  = 1'b1;
        ix_d  = 1'b1;
      end
      UNDERFLOW: begin
        // rounding up out of the denormal range lands on the minimum normal
        out_d = {sign2_q, {(EXP-1){1'b0}}, rnd};
        uf_d  = !rnd[FRAC];
      end
      default: begin
        if (exp_n == '1) begin
          out_d = {sign2_q, {EXP{1'b1}}, {FRAC{1'b0}}};
          ov_d  = 1'b1;
          ix_d  = 1'b1;
        end
      end
    endcase
  end

  logic [EXP+FRAC:0] out_q;
  logic              ov3_q, uf3_q, ix3_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_q  <= 1'b0;
      out_q <= '0;
      ov3_q <= 1'b0;
      uf3_q <= 1'b0;
      ix3_q <= 1'b0;
    end else if (adv3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_q <= out_d;
        ov3_q <= ov_d;
        uf3_q <= uf_d;
        ix3_q <= ix_d;
      end
    end
  end

  assign outData = out_q;

  logic [CNT_WIDTH-1:0] ov_cnt_q, uf_cnt_q, ix_cnt_q;
  logic                 deliver;

  assign deliver = v3_q && outReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ov_cnt_q <= '0;
      uf_cnt_q <= '0;
      ix_cnt_q <= '0;
    end else if (clearCounters) begin
      ov_cnt_q <= '0;
      uf_cnt_q <= '0;
      ix_cnt_q <= '0;
    end else if (deliver) begin
      if (ov3_q && ov_cnt_q != '1) ov_cnt_q <= ov_cnt_q + 1'b1;
      if (uf3_q && uf_cnt_q != '1) uf_cnt_q <= uf_cnt_q + 1'b1;
      if (ix3_q && ix_cnt_q != '1) ix_cnt_q <= ix_cnt_q + 1'b1;
    end
  end

  assign overflowCount  = ov_cnt_q;
  assign underflowCount = uf_cnt_q;
  assign inexactCount   = ix_cnt_q;

endmodule
